hs_ser_sched: RTL
=================

HS_SER_SCHED -- requirements
Module: hs_ser_sched

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL accept jobs on: job_valid in 1; job_ready out 1; job_mode in 2 (00 part1, 01 part2, 10 agch, 11 illegal); job_tag in 2; job_base_sys in 9; job_dec_bits in 29; job_ue_mask in 16.
REQ-003 SHALL drive the SER engine on: ser_start out 1; ser_hs_mode out 2; ser_codeblk_size_p7 out 6; ser_base_sys out 9; ser_dec_bits out 29; ser_ue_mask out 16; ser_done in 1; ser_acc in 7.
REQ-004 SHALL return results on: res_valid out 1; res_ready in 1; res_tag out 2; res_mode out 2; res_ser out 7; res_err out 1.
REQ-005 SHALL arbitrate DIRAM on: ser_rd_req in 1; ser_raddr in 9; ser_rd_ack out 1; ext_rd_req in 1; ext_raddr in 9; ext_rd_ack out 1; diram_rd_req out 1; diram_raddr out 9; diram_rd_ack in 1.
REQ-006 SHALL have parameter WDOG_MAX, default 1023, RUN-state cycle limit.

Function
REQ-007 Job FIFO SHALL be 4 entries deep, 58 bits wide (mode, tag, base_sys, dec_bits, ue_mask); job_ready = not full; push on job_valid & job_ready.
REQ-008 Simultaneous push and pop SHALL keep occupancy unchanged; pointers SHALL wrap modulo 4; a pop when empty SHALL NOT occur.
REQ-009 FSM states SHALL be IDLE, LAUNCH, RUN, RESULT.
REQ-010 IDLE: FIFO non-empty -> pop head into config registers; mode 11 -> RESULT with res_err=1, res_ser=0, no ser_start; otherwise -> LAUNCH.
REQ-011 ser_codeblk_size_p7 SHALL decode from latched mode: 00 -> 15, 01 -> 36, 10 -> 29; ser_* config outputs SHALL be stable from LAUNCH through RUN.
REQ-012 LAUNCH: ser_start high exactly one cycle, then -> RUN; watchdog counter cleared to 0.
REQ-013 RUN: ser_done high -> capture ser_acc into res_ser, res_err=0, -> RESULT; latency ser_done to res_valid = 1 cycle.
REQ-014 RUN: watchdog increments each cycle; reaching WDOG_MAX without ser_done -> res_ser=7'h7F, res_err=1, -> RESULT; ser_done arriving the same cycle SHALL take priority over timeout.
REQ-015 RESULT: res_valid high, res_tag/res_mode/res_ser/res_err held stable until res_ready; on res_valid & res_ready -> IDLE.
REQ-016 Back-to-back jobs SHALL incur exactly one IDLE cycle between RESULT handshake and next LAUNCH.
REQ-017 ser_done outside RUN SHALL be ignored.
REQ-018 DIRAM arbiter: requests are levels; when idle, grant one requester with a pending request; on contention round-robin, last-granted owner lowest priority.
REQ-019 Grant SHALL lock from the issue cycle until diram_rd_ack; diram_rd_req/diram_raddr SHALL present the owner's request combinationally while locked.
REQ-020 diram_rd_ack SHALL be routed only to the current owner's ack output, same cycle; next grant decision in the cycle after ack.
REQ-021 diram_rd_ack with no owner SHALL be ignored; no ack output asserts.

Reset
REQ-022 On rst: FIFO empty, job_ready=0 while rst asserted then 1, FSM IDLE, ser_start=0, res_valid=0, res_ser=0, res_err=0, res_tag=0, res_mode=0, no arbiter owner, round-robin favours ser, all ack outputs 0, diram_rd_req=0.
REQ-023 rst mid-job SHALL abandon the job and discard FIFO contents without producing a result.

Verification
REQ-024 Single part1 job, tag 1, base_sys 0x040; engine returns ser_acc=5 on ser_done -> ser_start one pulse, ser_codeblk_size_p7=15, ser_base_sys=0x040; res_valid with res_tag=1, res_ser=5, res_err=0.
REQ-025 Push 5 jobs with res_ready=0 -> job_ready low after 4th push accepted; results emerge in push order once res_ready=1.
REQ-026 Job mode 11 -> no ser_start; res_err=1, res_ser=0 within 2 cycles of pop.
REQ-027 WDOG_MAX=16, ser_done never asserted -> res_ser=7'h7F, res_err=1 after 16 RUN cycles; ser_done at cycle 16 instead -> res_err=0.
REQ-028 ser_rd_req and ext_rd_req both held, ack after 3 cycles each -> grants alternate ser, ext, ser; each ack reaches only owner; diram_raddr matches owner.
REQ-029 Assert rst during RUN with 2 jobs queued -> all outputs at reset values; no res_valid afterwards without new push.

Source files
------------

// File: rtl/hs_ser_sched.sv
// Job scheduler for the SER engine: 4-deep job FIFO, launch/run/result FSM
// with a RUN watchdog, and a two-way round-robin DIRAM read arbiter.
module hs_ser_sched #(
  parameter int WDOG_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [1:0]  job_mode,
  input  logic [1:0]  job_tag,
  input  logic [8:0]  job_base_sys,
  input  logic [28:0] job_dec_bits,
  input  logic [15:0] job_ue_mask,
  output logic        ser_start,
  output logic [1:0]  ser_hs_mode,
  output logic [5:0]  ser_codeblk_size_p7,
  output logic [8:0]  ser_base_sys,
  output logic [28:0] ser_dec_bits,
  output logic [15:0] ser_ue_mask,
  input  logic        ser_done,
  input  logic [6:0]  ser_acc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_tag,
  output logic [1:0]  res_mode,
  output logic [6:0]  res_ser,
  output logic        res_err,
  input  logic        ser_rd_req,
  input  logic [8:0]  ser_raddr,
  output logic        ser_rd_ack,
  input  logic        ext_rd_req,
  input  logic [8:0]  ext_raddr,
  output logic        ext_rd_ack,
  output logic        diram_rd_req,
  output logic [8:0]  diram_raddr,
  input  logic        diram_rd_ack
);

  localparam int WW = $clog2(WDOG_MAX + 1);

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  tag;
    logic [8:0]  base;
    logic [28:0] dec;
    logic [15:0] ue;
  } job_t;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESULT} state_t;

  // ---------------- job FIFO ----------------
  job_t       fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] cnt_q;
  logic       push, pop;
  job_t       head;

  assign job_ready = ~rst & (cnt_q != 3'd4);
  assign push      = job_valid & job_ready;
  assign head      = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{job_mode, job_tag, job_base_sys, job_dec_bits, job_ue_mask};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------- job FSM ----------------
  state_t        state_q, state_d;
  job_t          cfg_q, cfg_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [6:0]    res_ser_q, res_ser_d;
  logic          res_err_q, res_err_d;
  logic [1:0]    res_tag_q, res_tag_d;
  logic [1:0]    res_mode_q, res_mode_d;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    wdog_d     = wdog_q;
    res_ser_d  = res_ser_q;
    res_err_d  = res_err_q;
    res_tag_d  = res_tag_q;
    res_mode_d = res_mode_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != 3'd0) begin
          pop   = 1'b1;
          cfg_d = head;
          if (head.mode == 2'b11) begin
            res_ser_d  = 7'd0;
            res_err_d  = 1'b1;
            res_tag_d  = head.tag;
            res_mode_d = head.mode;
            state_d    = S_RESULT;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        res_tag_d  = cfg_q.tag;
        res_mode_d = cfg_q.mode;
        // done wins over a timeout landing on the same cycle
        if (ser_done) begin
          res_ser_d = ser_acc;
          res_err_d = 1'b0;
          state_d   = S_RESULT;
        end else if (wdog_q == WW'(WDOG_MAX - 1)) begin
          res_ser_d = 7'h7F;
          res_err_d = 1'b1;
          state_d   = S_RESULT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      wdog_q     <= '0;
      res_ser_q  <= '0;
      res_err_q  <= 1'b0;
      res_tag_q  <= '0;
      res_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      wdog_q     <= wdog_d;
      res_ser_q  <= res_ser_d;
      res_err_q  <= res_err_d;
      res_tag_q  <= res_tag_d;
      res_mode_q <= res_mode_d;
    end
  end

  always_comb begin
    case (cfg_q.mode)
      2'b00:   ser_codeblk_size_p7 = 6'd15;
      2'b01:   ser_codeblk_size_p7 = 6'd36;
      2'b10:   ser_codeblk_size_p7 = 6'd29;
      default: ser_codeblk_size_p7 = 6'd0;
    endcase
  end

  assign ser_start    = (state_q == S_LAUNCH);
  assign ser_hs_mode  = cfg_q.mode;
  assign ser_base_sys = cfg_q.base;
  assign ser_dec_bits = cfg_q.dec;
  assign ser_ue_mask  = cfg_q.ue;
  assign res_valid    = (state_q == S_RESULT);
  assign res_tag      = res_tag_q;
  assign res_mode     = res_mode_q;
  assign res_ser      = res_ser_q;
  assign res_err      = res_err_q;

  // ---------------- DIRAM arbiter ----------------
  // own/last: 0 = ser, 1 = ext; last resets to ext so ser wins first contention
  logic lock_q, own_q, last_q;
  logic any_req, own_nxt;

  assign any_req = ser_rd_req | ext_rd_req;

  always_comb begin
    own_nxt = 1'b0;
    if (ser_rd_req && ext_rd_req) own_nxt = ~last_q;
    else if (ext_rd_req)          own_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
      own_q  <= 1'b0;
      last_q <= 1'b1;
    end else if (!lock_q) begin
      if (any_req) begin
        lock_q <= 1'b1;
        own_q  <= own_nxt;
        last_q <= own_nxt;
      end
    end else if (diram_rd_ack) begin
      lock_q <= 1'b0;
    end
  end

  assign diram_rd_req = lock_q & (own_q ? ext_rd_req : ser_rd_req);
  assign diram_raddr  = lock_q ? (own_q ? ext_raddr : ser_raddr) : 9'd0;
  assign ser_rd_ack   = lock_q & ~own_q & diram_rd_ack;
  assign ext_rd_ack   = lock_q &  own_q & diram_rd_ack;

endmodule
